mips_multicycle_core: RTL and testbench



---
 rtl/mips_pkg.sv | 77 +++++++
 rtl/mips_regfile.sv | 38 +++
 rtl/mips_multicycle_core.sv | 151 +++++++++++++++
 tb/tb_mips_multicycle_core.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS core: opcode/funct values,
// FSM states, ALU ops, next-PC selects and the instruction decoder.
// Optional build macro: MIPS_HALT_ON_ILLEGAL_EN (adds the HALT state).
package mips_pkg;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpBlt   = 6'b001010;
  localparam logic [5:0] OpBgt   = 6'b001011;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnSlt = 6'b101010;
  localparam logic [5:0] FnJr  = 6'b001000;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExecute,
`ifdef MIPS_HALT_ON_ILLEGAL_EN
    StWriteback,
    StHalt
`else
    StWriteback
`endif
  } state_t;

  typedef enum logic [1:0] {AluAdd, AluSub, AluAnd, AluSlt} alu_op_t;
  typedef enum logic [1:0] {PcSeq, PcBranch, PcReg, PcJump} pc_sel_t;
  typedef enum logic [1:0] {BrEq, BrNe, BrLt, BrGt} br_cond_t;

  typedef struct packed {
    alu_op_t  alu_op;
    pc_sel_t  pc_sel;
    br_cond_t br_cond;
    logic     use_imm;  // ALU operand B is the sign-extended immediate
    logic     reg_we;
    logic     wr_rt;    // destination is rt (I-type) instead of rd
    logic     illegal;
  } ctrl_t;

  // Unsupported encodings decode as a NOP with the illegal bit set.
  function automatic ctrl_t decode(logic [31:0] ir);
    ctrl_t c;
    c = '{alu_op: AluAdd, pc_sel: PcSeq, br_cond: BrEq,
          use_imm: 1'b0, reg_we: 1'b0, wr_rt: 1'b0, illegal: 1'b0};
    case (ir[31:26])
      OpRtype: begin
        case (ir[5:0])
          FnAdd:   begin c.alu_op = AluAdd; c.reg_we = 1'b1; end
          FnSub:   begin c.alu_op = AluSub; c.reg_we = 1'b1; end
          FnAnd:   begin c.alu_op = AluAnd; c.reg_we = 1'b1; end
          FnSlt:   begin c.alu_op = AluSlt; c.reg_we = 1'b1; end
          FnJr:    c.pc_sel = PcReg;
          default: c.illegal = 1'b1;
        endcase
      end
      OpAddi: begin
        c.use_imm = 1'b1;
        c.reg_we  = 1'b1;
        c.wr_rt   = 1'b1;
      end
      OpBeq:   begin c.pc_sel = PcBranch; c.br_cond = BrEq; c.alu_op = AluSub; end
      OpBne:   begin c.pc_sel = PcBranch; c.br_cond = BrNe; c.alu_op = AluSub; end
      OpBlt:   begin c.pc_sel = PcBranch; c.br_cond = BrLt; c.alu_op = AluSub; end
      OpBgt:   begin c.pc_sel = PcBranch; c.br_cond = BrGt; c.alu_op = AluSub; end
      OpJ:     c.pc_sel = PcJump;
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// NREGS x XLEN register file: two combinational read ports, one synchronous
// write port, register 0 hard-wired to zero, synchronous clear on reset.
module mips_regfile #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  localparam int unsigned Aw   = $clog2(NREGS)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [Aw-1:0]   raddr_a_i,
  input  logic [Aw-1:0]   raddr_b_i,
  output logic [XLEN-1:0] rdata_a_o,
  output logic [XLEN-1:0] rdata_b_o,
  input  logic            we_i,
  input  logic [Aw-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i
);

  logic [XLEN-1:0] regs_q [NREGS];

  // Register array: clear on reset, writes to entry 0 are dropped.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports: entry 0 always reads as zero.
  always_comb begin
    rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
    rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];
  end

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS integer core: FETCH/DECODE/EXECUTE/WRITEBACK with a
// request/valid instruction fetch. Defining MIPS_HALT_ON_ILLEGAL_EN makes an
// unsupported instruction park the core in HALT until reset.
module mips_multicycle_core #(
  parameter int unsigned    XLEN     = 32,
  parameter int unsigned    NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] result,
  output logic            retire,
  output logic            illegal
);
  import mips_pkg::*;

  localparam int unsigned Aw = $clog2(NREGS);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, npc_q, npc_d;
  logic [XLEN-1:0] a_q, b_q, result_q;
  logic [31:0]     ir_q;
  logic            illegal_q;

  ctrl_t           ctrl;
  logic [Aw-1:0]   rs_idx, rt_idx, rd_idx;
  logic [XLEN-1:0] rdata_a, rdata_b;
  logic [XLEN-1:0] imm_sext, pc_plus4, op_b, alu_out;
  logic            br_taken;

  assign ctrl     = decode(ir_q);
  assign rs_idx   = ir_q[21 +: Aw];
  assign rt_idx   = ir_q[16 +: Aw];
  assign rd_idx   = ir_q[11 +: Aw];
  assign imm_sext = {{(XLEN-16){ir_q[15]}}, ir_q[15:0]};
  assign pc_plus4 = pc_q + XLEN'(4);
  assign op_b     = ctrl.use_imm ? imm_sext : b_q;

  mips_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk_i     (clk),
    .reset_i   (reset),
    .raddr_a_i (rs_idx),
    .raddr_b_i (rt_idx),
    .rdata_a_o (rdata_a),
    .rdata_b_o (rdata_b),
    .we_i      ((state_q == StWriteback) && ctrl.reg_we),
    .waddr_i   (ctrl.wr_rt ? rt_idx : rd_idx),
    .wdata_i   (result_q)
  );

  // ALU and branch comparator, evaluated on the operand latches.
  always_comb begin
    alu_out = '0;
    case (ctrl.alu_op)
      AluAdd:  alu_out = a_q + op_b;
      AluSub:  alu_out = a_q - op_b;
      AluAnd:  alu_out = a_q & op_b;
      AluSlt:  alu_out = {{(XLEN-1){1'b0}}, $signed(a_q) < $signed(op_b)};
      default: alu_out = '0;
    endcase
    br_taken = 1'b0;
    case (ctrl.br_cond)
      BrEq:    br_taken = (a_q == b_q);
      BrNe:    br_taken = (a_q != b_q);
      BrLt:    br_taken = $signed(a_q) < $signed(b_q);
      BrGt:    br_taken = $signed(a_q) > $signed(b_q);
      default: br_taken = 1'b0;
    endcase
  end

  // Next-PC selection; JR takes rs unmodified, even if misaligned.
  always_comb begin
    npc_d = pc_plus4;
    case (ctrl.pc_sel)
      PcSeq:    npc_d = pc_plus4;
      PcBranch: npc_d = br_taken ? (pc_plus4 + (imm_sext << 2)) : pc_plus4;
      PcReg:    npc_d = a_q;
      PcJump:   npc_d = {pc_plus4[XLEN-1:28], ir_q[25:0], 2'b00};
      default:  npc_d = pc_plus4;
    endcase
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:     if (imem_rvalid) state_d = StDecode;
`ifdef MIPS_HALT_ON_ILLEGAL_EN
      StDecode:    state_d = ctrl.illegal ? StHalt : StExecute;
      StHalt:      state_d = StHalt;
`else
      StDecode:    state_d = StExecute;
`endif
      StExecute:   state_d = StWriteback;
      StWriteback: state_d = StFetch;
      default:     state_d = StFetch;
    endcase
  end

  // State register and per-phase datapath latches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      npc_q     <= '0;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == StFetch) && imem_rvalid) begin
        ir_q <= imem_rdata;
      end
      if (state_q == StDecode) begin
        a_q <= rdata_a;
        b_q <= rdata_b;
        if (ctrl.illegal) begin
          illegal_q <= 1'b1;
        end
      end
      if (state_q == StExecute) begin
        result_q <= alu_out;
        npc_q    <= npc_d;
      end
      if (state_q == StWriteback) begin
        pc_q <= npc_q;
      end
    end
  end

  // Outputs; the request is masked during reset so a pending fetch is dropped.
  always_comb begin
    imem_req  = (state_q == StFetch) && !reset;
    imem_addr = pc_q;
    pc        = pc_q;
    result    = result_q;
    retire    = (state_q == StWriteback);
    illegal   = illegal_q;
  end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Scoreboard bench for mips_multicycle_core: the stimulus process serves
// instructions and queues expected fetch addresses and retire records; a
// negedge monitor pops and compares whenever the core fetches or retires.
module tb_mips_multicycle_core;

  localparam logic [31:0] ResetPc = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] result;
  logic        retire;
  logic        illegal;

  mips_multicycle_core #(
    .XLEN     (32),
    .NREGS    (32),
    .RESET_PC (ResetPc)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .pc          (pc),
    .result      (result),
    .retire      (retire),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] res;
    bit          chk_res;
    bit          ill;
    int          gap;
  } ret_t;

  logic [31:0] fetch_q[$];
  ret_t        ret_q[$];
  ret_t        mon_r;
  int          tests = 0;
  int          fails = 0;
  int          cycle = 0;
  int          last_ret = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each fetch and each retire against the queued expectations.
  always @(negedge clk) begin
    if (!reset) begin
      if (imem_req && imem_rvalid) begin
        if (fetch_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL fetch_unexpected: addr %h, expected no fetch", imem_addr);
        end else begin
          check("fetch_addr", imem_addr, fetch_q.pop_front());
        end
      end
      if (retire) begin
        if (ret_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL retire_unexpected: pc %h, expected no retire", pc);
        end else begin
          mon_r = ret_q.pop_front();
          check("retire_pc", pc, mon_r.pc);
          if (mon_r.chk_res) check("result", result, mon_r.res);
          check("illegal", {31'b0, illegal}, {31'b0, mon_r.ill});
          if (mon_r.gap > 0) check("retire_gap", 32'(cycle - last_ret), 32'(mon_r.gap));
        end
        last_ret = cycle;
      end
    end
  end

  function automatic logic [31:0] enc_r(logic [5:0] fn, logic [4:0] rs, logic [4:0] rt,
                                        logic [4:0] rd);
    return {6'b000000, rs, rt, rd, 5'b00000, fn};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(logic [25:0] idx);
    return {6'b000010, idx};
  endfunction

  // Serve one instruction at the next fetch after `waits` wait states and
  // queue what the core should show for it.
  task automatic serve(input logic [31:0] ins, input int waits, input logic [31:0] ipc,
                       input bit chk, input logic [31:0] res, input bit ill, input int gap,
                       input bit retires);
    int   n;
    ret_t e;
    fetch_q.push_back(ipc);
    if (retires) begin
      e.pc      = ipc;
      e.res     = res;
      e.chk_res = chk;
      e.ill     = ill;
      e.gap     = gap;
      ret_q.push_back(e);
    end
    n = 0;
    while (!imem_req && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!imem_req) begin
      tests++;
      fails++;
      $display("FAIL fetch_timeout: imem_req 0 after %0d cycles, expected 1 for pc %h", n, ipc);
      void'(fetch_q.pop_back());
      return;
    end
    repeat (waits) begin
      @(posedge clk); #1;
    end
    imem_rvalid = 1'b1;
    imem_rdata  = ins;
    @(posedge clk); #1;
    imem_rvalid = 1'b0;
  endtask

  localparam logic [5:0] Addi = 6'b001000, Beq = 6'b000100, Bne = 6'b000101;
  localparam logic [5:0] Blt = 6'b001010, Bgt = 6'b001011;
  localparam logic [5:0] Add = 6'b100000, Sub = 6'b100010, And = 6'b100100;
  localparam logic [5:0] Slt = 6'b101010, Jr = 6'b001000;

  initial begin
    int n;
    reset       = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_retire", {31'b0, retire}, 32'd0);
    check("rst_illegal", {31'b0, illegal}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_pc", pc, ResetPc);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("first_req", {31'b0, imem_req}, 32'd1);
    check("first_addr", imem_addr, ResetPc);

    serve(enc_i(Addi, 0, 1, 16'd5),    0, 32'h100, 1, 32'd5,         0, 0, 1);
    serve(enc_i(Addi, 0, 2, 16'hFFFD), 0, 32'h104, 1, 32'hFFFF_FFFD, 0, 4, 1);
    serve(enc_r(Add, 1, 2, 3),         0, 32'h108, 1, 32'd2,         0, 4, 1);
    serve(enc_i(Addi, 0, 5, 16'h0010), 0, 32'h10C, 1, 32'h10,        0, 4, 1);
    serve(enc_r(Jr, 5, 0, 0),          0, 32'h110, 0, 32'd0,         0, 4, 1);
    serve(enc_i(Beq, 1, 1, 16'd2),     0, 32'h010, 0, 32'd0,         0, 4, 1);
    serve(enc_i(Bne, 1, 1, 16'd2),     0, 32'h01C, 0, 32'd0,         0, 4, 1);
    serve(enc_j(26'h40),               0, 32'h020, 0, 32'd0,         0, 4, 1);
    serve(enc_i(Addi, 0, 1, 16'hFFFF), 0, 32'h100, 1, 32'hFFFF_FFFF, 0, 4, 1);
    serve(enc_i(Addi, 0, 2, 16'd1),    0, 32'h104, 1, 32'd1,         0, 4, 1);
    serve(enc_i(Blt, 1, 2, 16'd3),     0, 32'h108, 0, 32'd0,         0, 4, 1);
    serve(enc_i(Bgt, 1, 2, 16'd3),     0, 32'h118, 0, 32'd0,         0, 4, 1);
    serve(enc_r(Slt, 1, 2, 4),         0, 32'h11C, 1, 32'd1,         0, 4, 1);
    serve(enc_i(Addi, 0, 5, 16'h0200), 0, 32'h120, 1, 32'h200,       0, 4, 1);
    serve(enc_r(Jr, 5, 0, 0),          0, 32'h124, 0, 32'd0,         0, 4, 1);
    serve(enc_i(Addi, 0, 0, 16'd7),    0, 32'h200, 1, 32'd7,         0, 4, 1);
    serve(enc_r(Add, 0, 0, 6),         0, 32'h204, 1, 32'd0,         0, 4, 1);
    serve(enc_r(Add, 3, 4, 7),         0, 32'h208, 1, 32'd3,         0, 4, 1);
    serve(enc_r(Sub, 4, 3, 8),         0, 32'h20C, 1, 32'hFFFF_FFFF, 0, 4, 1);
    serve(enc_r(And, 1, 5, 9),         0, 32'h210, 1, 32'h200,       0, 4, 1);
    serve(enc_i(Addi, 0, 5, 16'h0010), 2, 32'h214, 1, 32'h10,        0, 6, 1);
    serve(enc_r(Jr, 5, 0, 0),          0, 32'h218, 0, 32'd0,         0, 4, 1);
    serve(enc_i(Bne, 1, 1, 16'd2),     0, 32'h010, 0, 32'd0,         0, 4, 1);
`ifdef MIPS_HALT_ON_ILLEGAL_EN
    serve(32'hFC00_0000,               0, 32'h014, 0, 32'd0,         1, 4, 0);
    repeat (10) begin
      @(posedge clk); #1;
    end
    check("halt_req", {31'b0, imem_req}, 32'd0);
    check("halt_pc", pc, 32'h014);
    check("halt_illegal", {31'b0, illegal}, 32'd1);
`else
    serve(32'hFC00_0000,               0, 32'h014, 0, 32'd0,         1, 4, 1);
    serve(enc_r(Add, 1, 1, 10),        0, 32'h018, 1, 32'hFFFF_FFFE, 1, 4, 1);
    // Reset lands while the fetch at 0x1C is still waiting on imem_rvalid.
    n = 0;
    while (!imem_req && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("midfetch_req", {31'b0, imem_req}, 32'd1);
    check("midfetch_addr", imem_addr, 32'h01C);
`endif
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    imem_rvalid = 1'b1;
    imem_rdata  = enc_i(Addi, 0, 1, 16'd9);
    @(posedge clk); #1;
    reset       = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    check("abort_pc", pc, ResetPc);
    check("abort_illegal", {31'b0, illegal}, 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_retire", {31'b0, retire}, 32'd0);

    serve(enc_r(Add, 1, 1, 11),        3, 32'h100, 1, 32'd0,         0, 0, 1);
    serve(enc_i(Addi, 0, 1, 16'd9),    0, 32'h104, 1, 32'd9,         0, 4, 1);
    serve(enc_r(Add, 1, 1, 12),        0, 32'h108, 1, 32'h12,        0, 4, 1);

    n = 0;
    while (ret_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("retire_queue_left", 32'(ret_q.size()), 32'd0);
    check("fetch_queue_left", 32'(fetch_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
